// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues single-outstanding word fetches and buffers
// the returned words in a first-word-fall-through queue drained by a valid/ready consumer.
module if_prefetch_queue #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [5:0]  HLT_OPCODE = 6'h3f
) (
    input  logic        clk1,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_stopped
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    // Fetch-side state
    logic [31:0]   r_fetch_pc;
    logic          r_req;
    logic [31:0]   r_addr;
    logic          r_pending;
    logic          r_drop;
    logic          r_stopped;

    // Queue state
    logic [31:0]   r_instr_mem [DEPTH];
    logic [31:0]   r_pc_mem    [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_rsp;
    logic          w_push;
    logic          w_pop;
    logic          w_hlt;
    logic [CW:0]   w_next_count;
    logic          w_can_issue;

    // A response only counts while a request is outstanding, so a word that
    // arrives after reset (pending cleared) is ignored.
    assign w_rsp  = imem_rvalid & r_pending;
    assign w_push = w_rsp & ~r_drop & ~redirect;
    assign w_pop  = out_valid & out_ready & ~redirect;
    assign w_hlt  = (imem_rdata[31:26] == HLT_OPCODE);

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // here via the defaults at the top, so no latch is inferred.
    always_comb begin
        w_next_count = {1'b0, r_count};
        w_can_issue  = 1'b0;
        w_next_count = {1'b0, r_count} + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};
        w_can_issue  = (~r_pending | w_rsp) & ~redirect & ~r_stopped
                       & ~(w_push & w_hlt) & (w_next_count < DEPTH_C);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_pending  <= 1'b0;
            r_drop     <= 1'b0;
            r_stopped  <= 1'b0;
        end else begin
            r_req <= w_can_issue;
            if (w_can_issue) begin
                r_addr     <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + 32'd1;
            end
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
            end

            if (w_can_issue) begin
                r_pending <= 1'b1;
            end else if (w_rsp) begin
                r_pending <= 1'b0;
            end

            // The one outstanding response after a redirect belongs to the old path.
            if (redirect) begin
                r_drop <= r_pending & ~imem_rvalid;
            end else if (w_rsp) begin
                r_drop <= 1'b0;
            end

            if (redirect) begin
                r_stopped <= 1'b0;
            end else if (w_push & w_hlt) begin
                r_stopped <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_next_count[CW-1:0];
        end
    end

    // NOTE: queue storage is not reset; out_valid qualifies every read, so
    // stale contents are never observed.
    always_ff @(posedge clk1) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= imem_rdata;
            r_pc_mem[r_wr_ptr]    <= r_addr;
        end
    end

    assign imem_req      = r_req;
    assign imem_addr     = r_addr;
    assign out_valid     = (r_count != '0);
    assign out_instr     = out_valid ? r_instr_mem[r_rd_ptr] : 32'h0;
    assign out_pc        = out_valid ? r_pc_mem[r_rd_ptr]    : 32'h0;
    assign fetch_stopped = r_stopped;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: a behavioural instruction memory with
// selectable latency, a request logger and a scoreboard on the output handshake.
module tb_if_prefetch_queue;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_stopped;

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .HLT_OPCODE(6'h3f)) dut (
        .clk1          (clk1),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_rvalid   (imem_rvalid),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .fetch_stopped (fetch_stopped)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        exp_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] mem [64];
    int          mem_lat = 1;
    int          cyc = 0;
    logic [31:0] req_addr_q[$];
    int          req_cyc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    task automatic push_prog();
        push_exp(32'h2801000a, 32'h0);
        push_exp(32'h28020014, 32'h1);
        push_exp(32'h28030019, 32'h2);
        push_exp(32'h0ce77800, 32'h3);
        push_exp(32'hfc000000, 32'h4);
    endtask

    task automatic push_tgt();
        push_exp(32'h28050001, 32'h10);
        push_exp(32'h28060002, 32'h11);
        push_exp(32'hfc000000, 32'h12);
    endtask

    task automatic wait_empty(input int max_cyc, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk1);
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    task automatic wait_req(input logic [31:0] addr, input string name, output int at_cyc);
        int n;
        logic found;
        n     = 0;
        found = 1'b0;
        while (!found && n < 200) begin
            @(negedge clk1);
            n++;
            if (imem_req && imem_addr == addr) found = 1'b1;
        end
        at_cyc = cyc;
        check({name, "_req_seen"}, {31'h0, found}, 32'h1);
    endtask

    task automatic do_reset();
        @(negedge clk1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk1);
        req_addr_q.delete();
        req_cyc_q.delete();
        rst_n = 1'b1;
    endtask

    // Instruction memory: a request seen in cycle N answers in cycle N+mem_lat.
    initial begin
        rsp_t r;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk1);
            if (imem_req) begin
                r.due  = cyc + mem_lat;
                r.data = mem[imem_addr[5:0]];
                rsp_q.push_back(r);
            end
            @(posedge clk1);
            #1;
            cyc++;
            if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
                r           = rsp_q.pop_front();
                imem_rvalid = 1'b1;
                imem_rdata  = r.data;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk1);
            if (imem_req) begin
                req_addr_q.push_back(imem_addr);
                req_cyc_q.push_back(cyc);
            end
        end
    end

    // Scoreboard: every accepted head is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk1);
            if (rst_n && out_valid && out_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected_pop: got pc %h expected no pop", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_instr", out_instr, e.instr);
                    check("sb_pc", out_pc, e.pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c2;
        int c10;
        int c;
        for (int i = 0; i < 64; i++) mem[i] = 32'h01000000 | 32'(i);
        mem[0]  = 32'h2801000a;
        mem[1]  = 32'h28020014;
        mem[2]  = 32'h28030019;
        mem[3]  = 32'h0ce77800;
        mem[4]  = 32'hfc000000;
        mem[16] = 32'h28050001;
        mem[17] = 32'h28060002;
        mem[18] = 32'hfc000000;

        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b0;
        #2;
        check("rst_imem_req", {31'h0, imem_req}, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_fetch_stopped", {31'h0, fetch_stopped}, 32'h0);

        // Streaming program with an always-ready consumer.
        mem_lat   = 1;
        out_ready = 1'b1;
        push_prog();
        do_reset();
        wait_empty(100, "p1");
        repeat (10) @(negedge clk1);
        check("p1_fetch_stopped", {31'h0, fetch_stopped}, 32'h1);
        check("p1_out_valid", {31'h0, out_valid}, 32'h0);
        check("p1_req_cnt", 32'(req_addr_q.size()), 32'h5);
        check("p1_last_addr", req_addr_q[req_addr_q.size() - 1], 32'h4);

        // Stalled consumer fills the queue, then a single pop frees one slot.
        out_ready = 1'b0;
        do_reset();
        repeat (30) @(negedge clk1);
        check("p2_req_cnt_full", 32'(req_addr_q.size()), 32'h4);
        check("p2_req_addr3", req_addr_q[3], 32'h3);
        check("p2_out_valid", {31'h0, out_valid}, 32'h1);
        check("p2_head_pc", out_pc, 32'h0);
        check("p2_head_instr", out_instr, 32'h2801000a);
        push_exp(32'h2801000a, 32'h0);
        @(posedge clk1);
        #1 out_ready = 1'b1;
        @(posedge clk1);
        #1 out_ready = 1'b0;
        repeat (6) @(negedge clk1);
        check("p2_one_pop", 32'(exp_q.size()), 32'h0);
        check("p2_req_cnt_after", 32'(req_addr_q.size()), 32'h5);
        check("p2_req_addr4", req_addr_q[req_addr_q.size() - 1], 32'h4);
        check("p2_head_pc_after", out_pc, 32'h1);
        push_exp(32'h28020014, 32'h1);
        push_exp(32'h28030019, 32'h2);
        push_exp(32'h0ce77800, 32'h3);
        push_exp(32'hfc000000, 32'h4);
        @(posedge clk1);
        #1 out_ready = 1'b1;
        wait_empty(100, "p2");
        check("p2_fetch_stopped", {31'h0, fetch_stopped}, 32'h1);

        // 3-cycle memory, redirect while the addr-2 fetch is in flight.
        mem_lat   = 3;
        out_ready = 1'b0;
        do_reset();
        wait_req(32'h2, "p3_addr2", c2);
        push_tgt();
        @(posedge clk1);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        @(posedge clk1);
        #1 redirect = 1'b0;
        @(negedge clk1);
        check("p3_flush_valid", {31'h0, out_valid}, 32'h0);
        check("p3_no_req", {31'h0, imem_req}, 32'h0);
        wait_req(32'h10, "p3_addr10", c10);
        check("p3_req10_cycle", 32'(c10 - c2), 32'h4);
        out_ready = 1'b1;
        wait_empty(100, "p3");
        check("p3_fetch_stopped", {31'h0, fetch_stopped}, 32'h1);

        // Redirect and ready together with two entries queued: no pop.
        mem_lat   = 1;
        out_ready = 1'b0;
        do_reset();
        wait_req(32'h2, "p4_addr2", c);
        check("p4_pre_valid", {31'h0, out_valid}, 32'h1);
        check("p4_pre_pc", out_pc, 32'h0);
        push_tgt();
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        out_ready   = 1'b1;
        @(posedge clk1);
        #1 redirect = 1'b0;
        @(negedge clk1);
        check("p4_flush_valid", {31'h0, out_valid}, 32'h0);
        wait_empty(100, "p4");
        repeat (5) @(negedge clk1);
        check("p4_fetch_stopped", {31'h0, fetch_stopped}, 32'h1);

        // Redirect out of the stopped state restarts fetch at 0.
        push_prog();
        @(posedge clk1);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        @(posedge clk1);
        #1 redirect = 1'b0;
        @(negedge clk1);
        check("p5_unstopped", {31'h0, fetch_stopped}, 32'h0);
        check("p5_no_req", {31'h0, imem_req}, 32'h0);
        wait_empty(100, "p5");
        repeat (5) @(negedge clk1);
        check("p5_fetch_stopped", {31'h0, fetch_stopped}, 32'h1);

        // Reset pulse while addr 1 is pending; its late response must be ignored.
        mem_lat   = 1;
        out_ready = 1'b0;
        do_reset();
        wait_req(32'h1, "p6_addr1", c);
        #2 rst_n = 1'b0;
        #1;
        check("p6_rst_imem_req", {31'h0, imem_req}, 32'h0);
        check("p6_rst_imem_addr", imem_addr, 32'h0);
        check("p6_rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("p6_rst_out_instr", out_instr, 32'h0);
        check("p6_rst_out_pc", out_pc, 32'h0);
        check("p6_rst_stopped", {31'h0, fetch_stopped}, 32'h0);
        @(negedge clk1);
        #2;
        req_addr_q.delete();
        req_cyc_q.delete();
        push_prog();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        wait_empty(100, "p6");
        repeat (5) @(negedge clk1);
        check("p6_first_addr", req_addr_q[0], 32'h0);
        check("p6_req_cnt", 32'(req_addr_q.size()), 32'h5);
        check("p6_fetch_stopped", {31'h0, fetch_stopped}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
